id_stage: RTL and testbench



---
 rtl/id_stage_pkg.sv | 60 ++++++
 rtl/reg_file.sv | 46 ++++
 rtl/id_stage.sv | 193 +++++++++++++++++++
 tb/tb_id_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_stage_pkg
// Definitions shared by the decode stage and the execute stage:
//   - primary opcode and R-type funct codes of the supported instruction set
//   - ALU operation encoding carried on ex_alu_op
//   - ctrl_t, the bundle of control bits produced by the decoder
//   - squash(), which turns a control bundle into a bubble
// ----------------------------------------------------------------------------
package id_stage_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (inst[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;    // 1 = second ALU operand is ex_imm
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  // A bubble keeps the ALU selection bits but drops every enable, so the
  // execute stage can act on the enables without looking at ex_valid.
  function automatic ctrl_t squash(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.mem_read  = 1'b0;
    r.mem_write = 1'b0;
    r.reg_write = 1'b0;
    r.branch    = 1'b0;
    r.jump      = 1'b0;
    r.illegal   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 32 x 32-bit register file with two combinational read ports and one write
// port. r0 always reads zero and ignores writes. A write in the same cycle as
// a read of the same (non-zero) register is bypassed to the read port.
//   clk, rst          clock, synchronous active-high reset (clears all regs)
//   rs_addr/rs_data   read port A
//   rt_addr/rt_data   read port B
//   we/waddr/wdata    write port
// ----------------------------------------------------------------------------
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_addr,
  output logic [31:0] rs_data,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  // NOTE: this array is cleared by reset because the architecture defines the
  // post-reset register values; memories without that need are left unreset
  // so they can map onto RAM macros.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs_data = (rs_addr == 5'd0)               ? '0    :
                   (we && (waddr == rs_addr))      ? wdata :
                                                     regs[rs_addr];

  assign rt_data = (rt_addr == 5'd0)               ? '0    :
                   (we && (waddr == rt_addr))      ? wdata :
                                                     regs[rt_addr];

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
// Instruction decode stage: decodes the fetched instruction, reads operands
// from the register file, detects load-use hazards and loads the ID/EX
// pipeline register.
//   clk, rst                        clock, synchronous active-high reset
//   if_valid/if_inst/if_pc          instruction from fetch
//   if_ready                        instruction accepted this cycle (comb.)
//   ex_stall                        execute stage holds the ID/EX register
//   id_flush                        squash the instruction being decoded
//   wb_we/wb_addr/wb_data           register-file write port from writeback
//   ex_*                            ID/EX register contents
// Edge priority: rst > id_flush > ex_stall > load-use hazard > advance.
// ----------------------------------------------------------------------------
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        ex_stall,
  input  logic        id_flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dst,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  assign opcode  = if_inst[31:26];
  assign rs_addr = if_inst[25:21];
  assign rt_addr = if_inst[20:16];
  assign rd_addr = if_inst[15:11];
  assign funct   = if_inst[5:0];

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs_addr),
    .rs_data (rs_data),
    .rt_addr (rt_addr),
    .rt_data (rt_data),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // --------------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------------
  ctrl_t       dec_ctrl;
  logic [4:0]  dec_dst;
  logic [31:0] dec_imm;
  logic        rt_used;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    dec_ctrl = '0;
    dec_dst  = '0;
    dec_imm  = {{16{if_inst[15]}}, if_inst[15:0]};
    rt_used  = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        rt_used            = 1'b1;
        dec_dst            = rd_addr;
        dec_ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
          FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
          FN_AND:  dec_ctrl.alu_op = ALU_AND;
          FN_OR:   dec_ctrl.alu_op = ALU_OR;
          FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
          default: begin
            dec_ctrl.reg_write = 1'b0;
            dec_ctrl.illegal   = 1'b1;
            dec_dst            = '0;
          end
        endcase
      end
      OP_LW: begin
        dec_dst            = rt_addr;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_SW: begin
        rt_used            = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        rt_used         = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        dec_ctrl.branch = 1'b1;
      end
      OP_J: begin
        dec_ctrl.jump = 1'b1;
        dec_imm       = {4'b0, if_inst[25:0], 2'b00};
      end
      OP_ADDI: begin
        dec_dst            = rt_addr;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_ORI: begin
        dec_dst            = rt_addr;
        dec_ctrl.alu_op    = ALU_OR;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_imm            = {16'b0, if_inst[15:0]};
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase

    // Writes to r0 are architecturally dead; drop them here so writeback
    // never has to special-case register zero.
    if (dec_dst == 5'd0) dec_ctrl.reg_write = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Load-use hazard and handshake
  // --------------------------------------------------------------------------
  ctrl_t ex_ctrl;
  logic  hz;

  assign hz = ex_valid && ex_ctrl.mem_read && (ex_dst != 5'd0) &&
              ((ex_dst == rs_addr) || (rt_used && (ex_dst == rt_addr)));

  // Flush deliberately does not gate if_ready: fetch is redirecting anyway.
  assign if_ready = !ex_stall && !hz;

  // --------------------------------------------------------------------------
  // ID/EX register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_dst     <= '0;
      ex_ctrl    <= '0;
    end else if (id_flush || (!ex_stall && hz)) begin
      // Bubble: only validity and enables matter, data fields are left as-is.
      ex_valid <= 1'b0;
      ex_ctrl  <= squash(ex_ctrl);
    end else if (!ex_stall) begin
      ex_valid   <= if_valid;
      ex_pc      <= if_pc;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= dec_imm;
      ex_dst     <= dec_dst;
      ex_ctrl    <= if_valid ? dec_ctrl : squash(dec_ctrl);
    end
  end

  assign ex_alu_op    = ex_ctrl.alu_op;
  assign ex_alu_src   = ex_ctrl.alu_src;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_jump      = ex_ctrl.jump;
  assign ex_illegal   = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage
// Directed scenarios followed by randomized traffic, all checked against an
// instruction-level reference model (register array + expected ID/EX record).
// ----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic        ex_stall = 1'b0;
  logic        id_flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_dst;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump, ex_illegal;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(if_ready), .ex_stall(ex_stall), .id_flush(id_flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_dst(ex_dst),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  dst;
    logic [2:0]  op;
    logic        src, mr, mw, rw, br, j, ill;
  } idex_m;

  idex_m       m;
  logic        known;     // 1 = every field of m is defined, not just v/enables
  logic [31:0] rf [32];

  function automatic idex_m kill(input idex_m x);
    idex_m r = x;
    r.v = 0; r.mr = 0; r.mw = 0; r.rw = 0; r.br = 0; r.j = 0; r.ill = 0;
    return r;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_we && wb_addr == a) return wb_data;
    return rf[a];
  endfunction

  function automatic string mnemonic(input logic [31:0] inst);
    logic [5:0] op = inst[31:26];
    logic [5:0] fn = inst[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h20) return "add";
      if (fn == 6'h22) return "sub";
      if (fn == 6'h24) return "and";
      if (fn == 6'h25) return "or";
      if (fn == 6'h2A) return "slt";
      return "bad";
    end
    if (op == 6'h23) return "lw";
    if (op == 6'h2B) return "sw";
    if (op == 6'h04) return "beq";
    if (op == 6'h02) return "j";
    if (op == 6'h08) return "addi";
    if (op == 6'h0D) return "ori";
    return "bad";
  endfunction

  function automatic idex_m model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic [31:0] rsd, input logic [31:0] rtd);
    idex_m d = '{default: 0};
    string mn = mnemonic(inst);
    d.v = 1; d.pc = pc; d.rs = rsd; d.rt = rtd;
    d.imm = {{16{inst[15]}}, inst[15:0]};
    case (mn)
      "add":  begin d.op = 0; d.dst = inst[15:11]; d.rw = 1; end
      "sub":  begin d.op = 1; d.dst = inst[15:11]; d.rw = 1; end
      "and":  begin d.op = 2; d.dst = inst[15:11]; d.rw = 1; end
      "or":   begin d.op = 3; d.dst = inst[15:11]; d.rw = 1; end
      "slt":  begin d.op = 4; d.dst = inst[15:11]; d.rw = 1; end
      "lw":   begin d.src = 1; d.mr = 1; d.dst = inst[20:16]; d.rw = 1; end
      "sw":   begin d.src = 1; d.mw = 1; end
      "beq":  begin d.op = 1; d.br = 1; end
      "j":    begin d.j = 1; d.imm = {4'b0, inst[25:0], 2'b00}; end
      "addi": begin d.src = 1; d.dst = inst[20:16]; d.rw = 1; end
      "ori":  begin d.op = 3; d.src = 1; d.dst = inst[20:16]; d.rw = 1;
                    d.imm = {16'h0, inst[15:0]}; end
      default: d.ill = 1;
    endcase
    if (d.dst == 0) d.rw = 0;
    return d;
  endfunction

  // One clock: check if_ready against the model, advance the model, then
  // check the ID/EX outputs after the edge. Called at posedge+1.
  task automatic cycle();
    logic       hz, rdy, rt_used;
    logic [4:0] ra, rb;
    string      mn;
    #1;
    ra = if_inst[25:21];
    rb = if_inst[20:16];
    mn = mnemonic(if_inst);
    rt_used = (if_inst[31:26] == 6'h00) || (mn == "sw") || (mn == "beq");
    hz  = m.v && m.mr && (m.dst != 0) && ((m.dst == ra) || (rt_used && m.dst == rb));
    rdy = !ex_stall && !hz;
    check("if_ready", 32'(if_ready), 32'(rdy));
    if (rst) begin
      m = '{default: 0};
      known = 1;
      foreach (rf[i]) rf[i] = '0;
    end else begin
      idex_m d = model_decode(if_inst, if_pc, rd_model(ra), rd_model(rb));
      if (wb_we && wb_addr != 0) rf[wb_addr] = wb_data;
      if (id_flush || (!ex_stall && hz)) begin
        m = kill(m); known = 0;
      end else if (!ex_stall) begin
        m = d; known = 1;
        if (!if_valid) begin m = kill(m); known = 0; end
      end
    end
    @(posedge clk); #1;
    check("ex_valid",     32'(ex_valid),     32'(m.v));
    check("ex_mem_read",  32'(ex_mem_read),  32'(m.mr));
    check("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
    check("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
    check("ex_branch",    32'(ex_branch),    32'(m.br));
    check("ex_jump",      32'(ex_jump),      32'(m.j));
    check("ex_illegal",   32'(ex_illegal),   32'(m.ill));
    if (known) begin
      check("ex_pc",      ex_pc,      m.pc);
      check("ex_rs_data", ex_rs_data, m.rs);
      check("ex_rt_data", ex_rt_data, m.rt);
      check("ex_imm",     ex_imm,     m.imm);
      check("ex_dst",     32'(ex_dst),     32'(m.dst));
      check("ex_alu_op",  32'(ex_alu_op),  32'(m.op));
      check("ex_alu_src", 32'(ex_alu_src), 32'(m.src));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if_valid = v; if_inst = inst; if_pc = pc;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  a = 5'($urandom_range(0, 7));
    logic [4:0]  b = 5'($urandom_range(0, 7));
    logic [4:0]  c = 5'($urandom_range(0, 7));
    logic [15:0] im = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return {6'h00, a, b, c, 5'h0, 6'h20};
      1:  return {6'h00, a, b, c, 5'h0, 6'h22};
      2:  return {6'h00, a, b, c, 5'h0, 6'h24};
      3:  return {6'h00, a, b, c, 5'h0, 6'h25};
      4:  return {6'h00, a, b, c, 5'h0, 6'h2A};
      5:  return {6'h23, a, b, im};
      6:  return {6'h2B, a, b, im};
      7:  return {6'h04, a, b, im};
      8:  return {6'h02, 26'($urandom)};
      9:  return {6'h08, a, b, im};
      10: return {6'h0D, a, b, im};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Raw reset edge so the DUT state is defined before the model takes over.
    rst = 1;
    @(posedge clk); #1;
    m = '{default: 0}; known = 1;
    foreach (rf[i]) rf[i] = '0;

    // Reset state
    cycle();
    check("rst_ex_valid", 32'(ex_valid), 32'h0);
    check("rst_ex_pc", ex_pc, 32'h0);
    rst = 0;

    // Write r5 then decode add r3,r5,r0
    wb_we = 1; wb_addr = 5; wb_data = 32'h12345678; drive(0, 32'h0, 32'h0);
    cycle();
    wb_we = 0; drive(1, 32'h00A01820, 32'h100);
    cycle();
    check("r034_rs_data", ex_rs_data, 32'h12345678);
    check("r034_dst", 32'(ex_dst), 32'd3);
    check("r034_alu_op", 32'(ex_alu_op), 32'd0);
    check("r034_reg_write", 32'(ex_reg_write), 32'd1);

    // lw r4,8(r1) then add r6,r4,r2
    drive(1, 32'h8C240008, 32'h104);
    cycle();
    drive(1, 32'h00823020, 32'h108);
    #1; check("r035_ready_low", 32'(if_ready), 32'h0);
    cycle();
    check("r035_bubble", 32'(ex_valid), 32'h0);
    cycle();
    check("r035_issue_valid", 32'(ex_valid), 32'h1);
    check("r035_issue_dst", 32'(ex_dst), 32'd6);

    // Bypass: write r7 in the same cycle as decode of or r8,r7,r7
    wb_we = 1; wb_addr = 7; wb_data = 32'h0000DEAD; drive(1, 32'h00E74025, 32'h10C);
    cycle();
    wb_we = 0;
    check("r036_rs", ex_rs_data, 32'h0000DEAD);
    check("r036_rt", ex_rt_data, 32'h0000DEAD);

    // Immediate extension and illegal opcode
    drive(1, 32'h2002FFFF, 32'h110);
    cycle();
    check("r037_addi_imm", ex_imm, 32'hFFFFFFFF);
    drive(1, 32'h3402FFFF, 32'h114);
    cycle();
    check("r037_ori_imm", ex_imm, 32'h0000FFFF);
    drive(1, 32'hFC000000, 32'h118);
    cycle();
    check("r037_illegal", 32'(ex_illegal), 32'h1);
    check("r037_ill_valid", 32'(ex_valid), 32'h1);
    check("r037_ill_rw", 32'(ex_reg_write), 32'h0);

    // Stall 3 cycles with flush in cycle 2
    drive(1, 32'h00430820, 32'h11C);
    cycle();
    ex_stall = 1;
    cycle();
    check("r038_stall1_valid", 32'(ex_valid), 32'h1);
    id_flush = 1;
    cycle();
    check("r038_flush_valid", 32'(ex_valid), 32'h0);
    id_flush = 0;
    cycle();
    check("r038_stall3_valid", 32'(ex_valid), 32'h0);
    ex_stall = 0;

    // Reset with a live instruction in ID/EX
    drive(1, 32'h8C240008, 32'h120);
    cycle();
    rst = 1; drive(1, 32'h00823020, 32'h124);   // also lands mid-hazard
    cycle();
    rst = 0;
    check("r038_rst_valid", 32'(ex_valid), 32'h0);
    check("r038_rst_imm", ex_imm, 32'h0);
    check("r038_rst_rs", ex_rs_data, 32'h0);
    check("r038_rst_dst", 32'(ex_dst), 32'h0);
    check("r038_rst_mr", 32'(ex_mem_read), 32'h0);
    #1; check("r031_ready_after_rst", 32'(if_ready), 32'h1);
    drive(1, 32'h00A01820, 32'h128);             // r5 was cleared by reset
    cycle();
    check("r030_r5_cleared", ex_rs_data, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      id_flush = ($urandom_range(0, 7) == 0);
      ex_stall = ($urandom_range(0, 3) == 0);
      wb_we    = ($urandom_range(0, 1) == 0);
      wb_addr  = 5'($urandom_range(0, 9));
      wb_data  = $urandom;
      drive(($urandom_range(0, 3) != 0), rand_inst(), $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
